// File: rtl/huff_pkg.sv
// huff_pkg
//   Shared definitions for the Huffman frame sequencer:
//   - default geometry (bytes per word, frame depth in words, bytes per line)
//   - sequencer state enumeration
//   - width helpers for word addresses, word counts and lane/line counters
package huff_pkg;

  localparam int DEF_WORD_BYTES = 20;
  localparam int DEF_MAX_WORDS  = 256;
  localparam int DEF_LINE_BYTES = 255;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    KICK  = 2'd2,
    WAIT  = 2'd3
  } seq_state_e;

  // Bits needed to index 0..n-1 (at least one bit).
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold a count 0..n.
  function automatic int count_bits(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int ADDR_W  = idx_bits(DEF_MAX_WORDS);
  localparam int COUNT_W = count_bits(DEF_MAX_WORDS);

endpackage

// File: rtl/huff_word_packer.sv
// huff_word_packer
//   Packs accepted bytes into WORD_BYTES-wide words, byte n of a word at
//   bits [8n+7:8n]. When the last lane fills, or a flush byte arrives, the
//   completed word (unfilled lanes forced to zero) is registered onto the
//   write port for exactly one cycle and the pack register restarts empty.
//
// Ports
//   clk, reset     : clock, asynchronous active-high reset
//   accept_i       : a byte is accepted this cycle
//   data_i         : accepted byte
//   flush_i        : accepted byte closes the word early (end of frame)
//   word_done_o    : combinational, this acceptance completes a word
//   wr_en_o        : registered write strobe, one cycle after completion
//   wr_data_o      : registered packed word (held between writes)
module huff_word_packer
  import huff_pkg::*;
#(
  parameter int WORD_BYTES = DEF_WORD_BYTES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    accept_i,
  input  logic [7:0]              data_i,
  input  logic                    flush_i,
  output logic                    word_done_o,
  output logic                    wr_en_o,
  output logic [WORD_BYTES*8-1:0] wr_data_o
);

  localparam int LANE_W = idx_bits(WORD_BYTES);

  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [WORD_BYTES*8-1:0] pack_q, pack_d;
  logic [WORD_BYTES*8-1:0] word_d;
  logic                    wr_en_q;
  logic [WORD_BYTES*8-1:0] wr_data_q;

  // Word as it would look with the incoming byte merged in: lanes below the
  // current lane come from the pack register, the current lane takes the
  // new byte, and every lane above it is explicitly zero.
  always_comb begin
    word_d = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (LANE_W'(k) < lane_q) begin
        word_d[8*k +: 8] = pack_q[8*k +: 8];
      end else if (LANE_W'(k) == lane_q) begin
        word_d[8*k +: 8] = data_i;
      end
    end
  end

  assign word_done_o = accept_i && (flush_i || (lane_q == LANE_W'(WORD_BYTES - 1)));

  always_comb begin
    lane_d = lane_q;
    pack_d = pack_q;
    if (accept_i) begin
      if (word_done_o) begin
        lane_d = '0;
        pack_d = '0;
      end else begin
        lane_d = lane_q + 1'b1;
        pack_d = word_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q    <= '0;
      pack_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      lane_q  <= lane_d;
      pack_q  <= pack_d;
      wr_en_q <= word_done_o;
      if (word_done_o) begin
        wr_data_q <= word_d;
      end
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: rtl/huff_frame_sequencer.sv
// huff_frame_sequencer
//   Collects a frame of source bytes into a word-addressed frame buffer,
//   then launches the Huffman encoder and waits for it to finish before
//   accepting the next frame.
//
//   FILL  : accept bytes, write a word whenever one completes
//   DRAIN : one cycle while the final word write is on the port
//   KICK  : start and frame_pulse high for one cycle
//   WAIT  : hold until enc_done, then clear per-frame state and refill
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both high; in_ready is high only in FILL, so a byte is never taken
// and dropped -- the source simply holds it while in_ready is low.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid/in_data/in_last/in_ready : byte source handshake
//   wr_en/wr_addr/wr_data : frame buffer write port
//   line_pulse            : cycle after every LINE_BYTES-th byte of a frame
//   frame_pulse, start    : one-cycle frame end / encoder launch (KICK)
//   enc_done              : encoder finished, honoured only in WAIT
//   frame_words           : words written in the current frame
//   busy                  : sequencer is not in FILL
//   ovf                   : frame was truncated at MAX_WORDS words
//   dbg_state             : current sequencer state
module huff_frame_sequencer
  import huff_pkg::*;
#(
  parameter int WORD_BYTES = DEF_WORD_BYTES,
  parameter int MAX_WORDS  = DEF_MAX_WORDS,
  parameter int LINE_BYTES = DEF_LINE_BYTES
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  input  logic [7:0]                         in_data,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic                               wr_en,
  output logic [idx_bits(MAX_WORDS)-1:0]     wr_addr,
  output logic [WORD_BYTES*8-1:0]            wr_data,
  output logic                               line_pulse,
  output logic                               frame_pulse,
  output logic                               start,
  input  logic                               enc_done,
  output logic [count_bits(MAX_WORDS)-1:0]   frame_words,
  output logic                               busy,
  output logic                               ovf,
  output seq_state_e                         dbg_state
);

  localparam int A_W    = idx_bits(MAX_WORDS);
  localparam int C_W    = count_bits(MAX_WORDS);
  localparam int LINE_W = idx_bits(LINE_BYTES);

  seq_state_e        state_q;
  logic [A_W-1:0]    word_idx_q;
  logic [A_W-1:0]    wr_addr_q;
  logic [C_W-1:0]    frame_words_q;
  logic [LINE_W-1:0] line_cnt_q;
  logic              line_pulse_q;
  logic              start_q;
  logic              frame_pulse_q;
  logic              ovf_q;

  logic accept;
  logic word_done;

  assign in_ready = (state_q == FILL);
  assign accept   = in_valid && in_ready;

  huff_word_packer #(
    .WORD_BYTES (WORD_BYTES)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .accept_i    (accept),
    .data_i      (in_data),
    .flush_i     (in_last),
    .word_done_o (word_done),
    .wr_en_o     (wr_en),
    .wr_data_o   (wr_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FILL;
      word_idx_q    <= '0;
      wr_addr_q     <= '0;
      frame_words_q <= '0;
      line_cnt_q    <= '0;
      line_pulse_q  <= 1'b0;
      start_q       <= 1'b0;
      frame_pulse_q <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      line_pulse_q  <= 1'b0;
      start_q       <= 1'b0;
      frame_pulse_q <= 1'b0;

      if (accept) begin
        if (line_cnt_q == LINE_W'(LINE_BYTES - 1)) begin
          line_cnt_q   <= '0;
          line_pulse_q <= 1'b1;
        end else begin
          line_cnt_q <= line_cnt_q + 1'b1;
        end
      end

      // The address goes out alongside the packer's registered word.
      if (word_done) begin
        wr_addr_q     <= word_idx_q;
        word_idx_q    <= word_idx_q + 1'b1;
        frame_words_q <= frame_words_q + 1'b1;
      end

      case (state_q)
        FILL: begin
          // The line counter clear overrides the increment above; a line
          // pulse due on the final byte still fires.
          if (accept && in_last) begin
            state_q    <= DRAIN;
            line_cnt_q <= '0;
          end else if (word_done && (word_idx_q == A_W'(MAX_WORDS - 1))) begin
            state_q    <= DRAIN;
            ovf_q      <= 1'b1;
            line_cnt_q <= '0;
          end
        end
        DRAIN: begin
          state_q       <= KICK;
          start_q       <= 1'b1;
          frame_pulse_q <= 1'b1;
        end
        KICK: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (enc_done) begin
            state_q       <= FILL;
            word_idx_q    <= '0;
            frame_words_q <= '0;
            line_cnt_q    <= '0;
            ovf_q         <= 1'b0;
          end
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

  assign wr_addr     = wr_addr_q;
  assign frame_words = frame_words_q;
  assign line_pulse  = line_pulse_q;
  assign start       = start_q;
  assign frame_pulse = frame_pulse_q;
  assign ovf         = ovf_q;
  assign busy        = (state_q != FILL);
  assign dbg_state   = state_q;

endmodule

// File: doc/huff_frame_sequencer.md
HUFF_FRAME_SEQUENCER -- requirements
Module: huff_frame_sequencer

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 20, meaning bytes packed per memory word.
REQ-002 SHALL have parameter MAX_WORDS, default 256, meaning frame buffer depth in words.
REQ-003 SHALL have parameter LINE_BYTES, default 255, meaning accepted bytes per image line.
REQ-004 SHALL have port clk, input, 1, meaning rising-edge clock for all state.
REQ-005 SHALL have port reset, input, 1, meaning reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1, meaning source byte valid.
REQ-007 SHALL have port in_data, input, 8, meaning source byte.
REQ-008 SHALL have port in_last, input, 1, meaning this byte ends the frame.
REQ-009 SHALL have port in_ready, output, 1, meaning sequencer accepts a byte this cycle.
REQ-010 SHALL have port wr_en, output, 1, meaning frame-buffer write strobe.
REQ-011 SHALL have port wr_addr, output, 8, meaning frame-buffer word address.
REQ-012 SHALL have port wr_data, output, 160, meaning packed word; byte k at bits [8k+7:8k].
REQ-013 SHALL have port line_pulse, output, 1, meaning one-cycle end-of-line marker.
REQ-014 SHALL have port frame_pulse, output, 1, meaning one-cycle end-of-frame marker.
REQ-015 SHALL have port start, output, 1, meaning one-cycle encoder launch.
REQ-016 SHALL have port enc_done, input, 1, meaning encoder finished the frame.
REQ-017 SHALL have port frame_words, output, 9, meaning words written in the current frame.
REQ-018 SHALL have port busy, output, 1, meaning not in FILL.
REQ-019 SHALL have port ovf, output, 1, meaning frame truncated at MAX_WORDS.

Function
REQ-020 SHALL implement states FILL, DRAIN, KICK, WAIT.
REQ-021 SHALL set in_ready=1 only in FILL; byte accepted when in_valid&in_ready.
REQ-022 SHALL store accepted byte n (n = 0..WORD_BYTES-1 within word) at bits [8n+7:8n] of the pack register.
REQ-023 SHALL, on acceptance of byte WORD_BYTES-1, assert wr_en exactly one cycle later with that word and wr_addr equal to the current word index, then increment the word index and frame_words.
REQ-024 SHALL, on acceptance of a byte with in_last, zero all unfilled byte lanes, write the word the next cycle, and enter DRAIN.
REQ-025 SHALL, when in_last coincides with byte WORD_BYTES-1, issue exactly one write, with no extra padding word.
REQ-026 SHALL, when the word at address MAX_WORDS-1 fills without in_last, write it, set ovf, and enter DRAIN.
REQ-027 SHALL move DRAIN->KICK after one cycle; in KICK, pulse start and frame_pulse together for one cycle, then enter WAIT.
REQ-028 SHALL hold frame_words stable from DRAIN until leaving WAIT.
REQ-029 SHALL, in WAIT, on enc_done go to FILL next cycle, clearing word index, byte lane, frame_words, line counter, and ovf.
REQ-030 SHALL ignore enc_done outside WAIT.
REQ-031 SHALL pulse line_pulse the cycle after every LINE_BYTES-th accepted byte of a frame; the line counter wraps to 0 and is cleared at frame end.
REQ-032 SHALL drop source bytes only by in_ready=0, never silently.

Reset
REQ-033 SHALL, on reset assertion at any time, including mid-frame, immediately enter FILL with wr_en, start, frame_pulse, line_pulse, ovf and busy at 0, wr_addr=0, wr_data=0, frame_words=0, and the pack register cleared.
REQ-034 SHALL discard any partial word on reset, with no write issued.

Structure
REQ-035 SHALL place the state enumeration, WORD_BYTES/MAX_WORDS/LINE_BYTES defaults, and address/count widths in shared package huff_pkg.
REQ-036 SHALL implement byte-lane packing, zero-fill, and the write register in sub-module huff_word_packer.

Verification
REQ-037 SHALL cover a 40-byte frame with in_last on byte 39 -> two writes, addr 0 and 1; start one cycle after DRAIN; frame_words=2.
REQ-038 SHALL cover a 23-byte frame -> second word holds bytes 20-22 in bits [23:0], bits [159:24]=0; frame_words=2.
REQ-039 SHALL cover 5120 bytes with no in_last -> 256 writes, ovf=1, start pulsed, in_ready=0 until enc_done.
REQ-040 SHALL cover 510 bytes with in_valid held high -> line_pulse after byte 254 and after byte 509; enc_done pulsed before WAIT ignored.
REQ-041 SHALL cover reset asserted after byte 10 of a frame -> no write; the next frame's first word lands at addr 0.
REQ-042 SHALL cover random in_valid gaps over a 100-byte frame -> wr_data matches the reference byte ordering, and exactly one start per frame.
